// File: rtl/nvm_spi_reader_if.sv
// Requester handshake and SPI pin bundle for nvm_spi_reader.
// The abort/aborted pair exists only when NVM_SPI_ABORT_EN is defined.
interface nvm_spi_reader_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [15:0]      addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             cs_n;
    logic             sck;
    logic             si;
    logic             so;
`ifdef NVM_SPI_ABORT_EN
    logic             abort;
    logic             aborted;

    // master: requester plus the NVM side that drives so; slave: the reader
    modport master (
        output start, addr, len, so, abort,
        input  busy, done, rd_data, rd_valid, cs_n, sck, si, aborted
    );
    modport slave (
        input  start, addr, len, so, abort,
        output busy, done, rd_data, rd_valid, cs_n, sck, si, aborted
    );
`else
    modport master (
        output start, addr, len, so,
        input  busy, done, rd_data, rd_valid, cs_n, sck, si
    );
    modport slave (
        input  start, addr, len, so,
        output busy, done, rd_data, rd_valid, cs_n, sck, si
    );
`endif
endinterface

// File: rtl/nvm_spi_reader.sv
// SPI mode-0 master issuing READ (0x03) + 16-bit address, streaming bytes back.
// Optional abort support is compiled in with NVM_SPI_ABORT_EN.
module nvm_spi_reader #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 16
) (
    input logic             clk,
    input logic             rst_n,
    nvm_spi_reader_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CMD  = 3'd1;
    localparam logic [2:0] ADDR = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] TAIL = 3'd4;
    localparam logic [2:0] GAP  = 3'd5;

    localparam logic [7:0] READ_OP   = 8'h03;
    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

    logic [2:0]       state_reg;
    logic [8:0]       div_reg;
    logic [4:0]       bit_reg;
    logic [22:0]      out_sr_reg;
    logic [7:0]       in_sr_reg;
    logic [LEN_W-1:0] byte_cnt_reg;
    logic             byte_pend_reg;
    logic             cs_n_reg;
    logic             sck_reg;
    logic             si_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [7:0]       rd_data_reg;
    logic             rd_valid_reg;
    logic             half_end;
    logic             abort_req;

    assign half_end = (div_reg == HALF_LAST);

`ifdef NVM_SPI_ABORT_EN
    logic abort_flag_reg;
    logic aborted_reg;
    assign abort_req   = bus.abort && (state_reg == CMD || state_reg == ADDR || state_reg == DATA);
    assign bus.aborted = aborted_reg;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            div_reg       <= '0;
            bit_reg       <= '0;
            out_sr_reg    <= '0;
            in_sr_reg     <= '0;
            byte_cnt_reg  <= '0;
            byte_pend_reg <= 1'b0;
            cs_n_reg      <= 1'b1;
            sck_reg       <= 1'b0;
            si_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
`ifdef NVM_SPI_ABORT_EN
            abort_flag_reg <= 1'b0;
            aborted_reg    <= 1'b0;
`endif
        end else begin
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
`ifdef NVM_SPI_ABORT_EN
            aborted_reg  <= 1'b0;
`endif
            // Byte completed on the previous rising sck is published one edge later
            if (byte_pend_reg && !abort_req) begin
                rd_valid_reg  <= 1'b1;
                rd_data_reg   <= in_sr_reg;
                byte_pend_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    div_reg <= '0;
                    // A start coinciding with done is dropped; requester re-asserts
                    if (bus.start && !done_reg) begin
                        if (bus.len == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            out_sr_reg   <= {READ_OP[6:0], bus.addr};
                            si_reg       <= READ_OP[7];
                            cs_n_reg     <= 1'b0;
                            busy_reg     <= 1'b1;
                            byte_cnt_reg <= bus.len;
                            bit_reg      <= '0;
                            state_reg    <= CMD;
                        end
                    end
                end
                CMD, ADDR, DATA: begin
                    if (abort_req) begin
                        sck_reg       <= 1'b0;
                        si_reg        <= 1'b0;
                        div_reg       <= '0;
                        byte_pend_reg <= 1'b0;
                        state_reg     <= TAIL;
`ifdef NVM_SPI_ABORT_EN
                        abort_flag_reg <= 1'b1;
`endif
                    end else if (!half_end) begin
                        div_reg <= div_reg + 9'd1;
                    end else begin
                        div_reg <= '0;
                        sck_reg <= !sck_reg;
                        if (!sck_reg) begin
                            if (state_reg == DATA) begin
                                in_sr_reg <= {in_sr_reg[6:0], bus.so};
                                if (bit_reg == 5'd7)
                                    byte_pend_reg <= 1'b1;
                            end
                        end else if (state_reg == DATA) begin
                            if (bit_reg == 5'd7) begin
                                bit_reg      <= '0;
                                byte_cnt_reg <= byte_cnt_reg - LEN_W'(1);
                                if (byte_cnt_reg == LEN_W'(1))
                                    state_reg <= TAIL;
                            end else begin
                                bit_reg <= bit_reg + 5'd1;
                            end
                        end else begin
                            // End of a CMD/ADDR bit: present the next outgoing bit
                            si_reg     <= out_sr_reg[22];
                            out_sr_reg <= {out_sr_reg[21:0], 1'b0};
                            bit_reg    <= bit_reg + 5'd1;
                            if (state_reg == CMD && bit_reg == 5'd7)
                                state_reg <= ADDR;
                            if (state_reg == ADDR && bit_reg == 5'd23) begin
                                state_reg <= DATA;
                                si_reg    <= 1'b0;
                                bit_reg   <= '0;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (half_end) begin
                        cs_n_reg  <= 1'b1;
                        div_reg   <= '0;
                        state_reg <= GAP;
                    end else begin
                        div_reg <= div_reg + 9'd1;
                    end
                end
                GAP: begin
                    if (div_reg == GAP_LAST) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        div_reg   <= '0;
                        state_reg <= IDLE;
`ifdef NVM_SPI_ABORT_EN
                        aborted_reg    <= abort_flag_reg;
                        abort_flag_reg <= 1'b0;
`endif
                    end else begin
                        div_reg <= div_reg + 9'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.cs_n     = cs_n_reg;
    assign bus.sck      = sck_reg;
    assign bus.si       = si_reg;
endmodule
